// File: rtl/binary_to_bcd.sv
// ============================================================================
//  binary_to_bcd : sequential double-dabble binary -> packed BCD converter
//  Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
//  Revision 1.0
// ============================================================================
`default_nettype none

module binary_to_bcd #(
   parameter int          BIN_WIDTH  = 27,
   parameter int          DIGITS     = 8,
   parameter logic [3:0]  BLANK_CODE = 4'hF
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [BIN_WIDTH-1:0]  bin_in,
   input  logic                  start_in,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  overflow_out
);

   localparam int c_bcd_w = 4 * DIGITS;
   localparam int c_cnt_w = $clog2(BIN_WIDTH + 1);

   function automatic logic [127:0] f_pow10_m1(input int n);
      logic [127:0] p;
      p = 128'd1;
      for (int i = 0; i < n; i++) p = p * 128'd10;
      return p - 128'd1;
   endfunction

   localparam logic [127:0] c_max_val = f_pow10_m1(DIGITS);
   localparam logic [127:0] c_bin_max = (128'd1 << BIN_WIDTH) - 128'd1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   logic [BIN_WIDTH-1:0]  r_shift;
   logic [c_bcd_w-1:0]    r_scratch;
   logic [c_cnt_w-1:0]    r_cnt;
   logic                  r_ovf;
   logic                  w_ovf_in;
   logic [c_bcd_w-1:0]    w_adj;
   logic [c_bcd_w-1:0]    w_result;

   // When the input range cannot exceed the digit range, overflow is constant 0.
   generate
      if (c_bin_max > c_max_val) begin : g_ovf_cmp
         assign w_ovf_in = (128'(bin_in) > c_max_val);
      end else begin : g_no_ovf
         assign w_ovf_in = 1'b0;
      end
   endgenerate

   always_comb begin
      w_adj = r_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5)
            w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic w_lead;

   // Digit 0 is never blanked; saturated nines contain no zeros to blank.
   always_comb begin
      w_result = r_ovf ? {DIGITS{4'h9}} : r_scratch;
      w_lead   = 1'b1;
      for (int d = DIGITS - 1; d > 0; d--) begin
         if (w_lead && (w_result[4*d +: 4] == 4'd0))
            w_result[4*d +: 4] = BLANK_CODE;
         else
            w_lead = 1'b0;
      end
   end
`else
   always_comb begin
      w_result = r_ovf ? {DIGITS{4'h9}} : r_scratch;
   end
`endif

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_scratch    <= '0;
         r_cnt        <= '0;
         r_ovf        <= 1'b0;
         bcd_out      <= '0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
         overflow_out <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_in) begin
                  r_shift   <= bin_in;
                  r_scratch <= '0;
                  r_cnt     <= '0;
                  r_ovf     <= w_ovf_in;
                  busy_out  <= 1'b1;
                  r_state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (r_cnt == c_cnt_w'(BIN_WIDTH)) begin
                  bcd_out      <= w_result;
                  overflow_out <= r_ovf;
                  done_out     <= 1'b1;
                  r_state      <= S_DONE;
               end else begin
                  r_scratch <= {w_adj[c_bcd_w-2:0], r_shift[BIN_WIDTH-1]};
                  r_shift   <= {r_shift[BIN_WIDTH-2:0], 1'b0};
                  r_cnt     <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               busy_out <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd.sv
// ============================================================================
//  tb_binary_to_bcd : randomized self-checking bench for binary_to_bcd
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_binary_to_bcd;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [26:0] bin_in = '0;
   logic        start_in = 1'b0;
   logic [31:0] bcd_out;
   logic        busy_out;
   logic        done_out;
   logic        overflow_out;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_bcd = '0;
   logic        last_ovf = 1'b0;

   binary_to_bcd #(.BIN_WIDTH(27), .DIGITS(8), .BLANK_CODE(4'hF)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .bin_in       (bin_in),
      .start_in     (start_in),
      .bcd_out      (bcd_out),
      .busy_out     (busy_out),
      .done_out     (done_out),
      .overflow_out (overflow_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits by division, saturate above 99999999.
   function automatic logic [31:0] model(input longint v);
      logic [31:0] r;
      longint      x;
      r = '0;
      if (v > 64'd99999999) return 32'h99999999;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 7; i > 0; i--) begin
         if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
         else break;
      end
`endif
      return r;
   endfunction

   task automatic watch_no_done(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk_in); #1;
         if (done_out) seen++;
      end
      check(tag, seen, 0);
   endtask

   task automatic convert(input logic [26:0] v, input logic [31:0] exp_bcd,
                          input logic exp_ovf, input bit pulse_busy);
      int lat;
      lat = -1;
      @(negedge clk_in);
      bin_in   = v;
      start_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      bin_in   = 27'($urandom);
      check("busy_after_accept", busy_out, 1'b1);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk_in); #1;
         bin_in = 27'($urandom);
         if (pulse_busy && (k == 5 || k == 27 || k == 28)) begin
            start_in = 1'b1;
            bin_in   = 27'd777;
         end else begin
            start_in = 1'b0;
         end
         if (k == 27) begin
            check("bcd_hold", bcd_out, last_bcd);
            check("ovf_hold", overflow_out, last_ovf);
         end
         if (done_out) begin
            lat = k;
            break;
         end
      end
      check("done_latency", lat, 28);
      check("bcd_result", bcd_out, exp_bcd);
      check("ovf_result", overflow_out, exp_ovf);
      check("busy_in_done", busy_out, 1'b1);
      @(posedge clk_in); #1;
      start_in = 1'b0;
      check("done_single", done_out, 1'b0);
      check("busy_cleared", busy_out, 1'b0);
      last_bcd = exp_bcd;
      last_ovf = exp_ovf;
   endtask

   initial begin
      logic [26:0] rv;
      logic [31:0] zero_exp;
`ifdef LEADING_ZERO_BLANK_EN
      zero_exp = 32'hFFFFFFF0;
`else
      zero_exp = 32'h00000000;
`endif
      #1;
      check("por_bcd", bcd_out, 32'h0);
      check("por_busy", busy_out, 1'b0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;

      convert(27'd12345678, 32'h12345678, 1'b0, 1'b0);

      // Asynchronous reset in mid-cycle clears outputs without a clock edge.
      @(posedge clk_in); #3;
      rst_in = 1'b1;
      #1;
      check("arst_bcd", bcd_out, 32'h0);
      check("arst_busy", busy_out, 1'b0);
      check("arst_done", done_out, 1'b0);
      check("arst_ovf", overflow_out, 1'b0);
      @(negedge clk_in);
      rst_in   = 1'b0;
      last_bcd = '0;
      last_ovf = 1'b0;

      convert(27'd0,         zero_exp,     1'b0, 1'b0);
      convert(27'd99999999,  32'h99999999, 1'b0, 1'b0);
      convert(27'd100000000, 32'h99999999, 1'b1, 1'b0);
      convert(27'd134217727, 32'h99999999, 1'b1, 1'b0);

      convert(27'd555, model(555), 1'b0, 1'b1);
      watch_no_done("busy_no_extra_done", 35);
      check("busy_bcd_kept", bcd_out, model(555));
      convert(27'd777, model(777), 1'b0, 1'b0);

      // Reset during a conversion: no done pulse, outputs cleared.
      @(negedge clk_in);
      bin_in   = 27'd4321;
      start_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      repeat (10) @(posedge clk_in);
      #2;
      rst_in = 1'b1;
      #1;
      check("midconv_rst_bcd", bcd_out, 32'h0);
      check("midconv_rst_busy", busy_out, 1'b0);
      @(negedge clk_in);
      rst_in   = 1'b0;
      last_bcd = '0;
      last_ovf = 1'b0;
      watch_no_done("midconv_no_done", 35);
      convert(27'd9, model(9), 1'b0, 1'b0);

`ifdef LEADING_ZERO_BLANK_EN
      convert(27'd42,       32'hFFFFFF42, 1'b0, 1'b0);
      convert(27'd0,        32'hFFFFFFF0, 1'b0, 1'b0);
      convert(27'd10000000, 32'h10000000, 1'b0, 1'b0);
`endif

      for (int i = 0; i < 12; i++) begin
         if (i % 3 == 0) rv = 27'($urandom);
         else if (i % 3 == 1) rv = 27'($urandom_range(0, 99999999));
         else rv = 27'($urandom_range(0, 9999));
         convert(rv, model(longint'(rv)), (rv > 27'd99999999), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
